// File: rtl/kalman_pkg.sv
// Shared definitions for the Kalman filter sequencer: Q20.12 constants,
// default sizing and the sequencer state encoding.
package kalman_pkg;

   // Q20.12 fixed-point format used by all compute engines
   localparam int FRAC_BITS = 12;
   localparam int ONE       = 1 << FRAC_BITS;

   // Default sizing of the filter
   localparam int N_DEF       = 6;
   localparam int M_DEF       = 4;
   localparam int W_DEF       = 32;
   localparam int TIMEOUT_DEF = 4096;
   localparam int ICW_DEF     = 16;

   // Sequencer state encoding
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PREDICT = 2'd1;
   localparam logic [1:0] ST_GAIN    = 2'd2;
   localparam logic [1:0] ST_UPDATE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      PREDICT = ST_PREDICT,
      GAIN    = ST_GAIN,
      UPDATE  = ST_UPDATE
   } seq_state_e;

endpackage

// File: rtl/kalman_stage_watchdog.sv
// Per-stage watchdog: counts cycles spent waiting on the current engine and
// raises a one-cycle expire pulse when TIMEOUT waiting cycles pass with no
// done. TIMEOUT = 0 disables the expire output.
module kalman_stage_watchdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,   // restart the count (idle or stage completing)
   input  logic wait_i,    // a stage is outstanding this cycle
   input  logic done_i,    // the outstanding stage completes this cycle
   output logic expire_o
);

   localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear has priority, otherwise count waiting cycles
   always_comb begin
      // NOTE: every signal driven here gets a default first so no latch is inferred.
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (wait_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Waiting-cycle counter register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The TIMEOUT-th waiting cycle without a done expires the stage
   assign expire_o = (TIMEOUT != 0) && wait_i && !done_i && (cnt_q == LAST);

endmodule

// File: rtl/kalman_seq_ctrl.sv
// Closed-loop Kalman iteration sequencer. Holds the committed filter state,
// launches predict/gain/update engines with one-cycle start pulses, supports
// predict-only iterations, a per-stage watchdog and an iteration counter.
module kalman_seq_ctrl
   import kalman_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int M       = M_DEF,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int ICW     = ICW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic [N*W-1:0]       x_init_flat,
   input  logic [N*N*W-1:0]     P_init_flat,
   input  logic                 start,
   input  logic                 meas_valid,
   input  logic [M*W-1:0]       z_flat,
   output logic [N*W-1:0]       x_state_flat,
   output logic [N*N*W-1:0]     P_state_flat,
   output logic [M*W-1:0]       z_q_flat,
   output logic [N*W-1:0]       xhat_q_flat,
   output logic [N*N*W-1:0]     Phat_q_flat,
   output logic                 pred_start,
   input  logic                 pred_done,
   input  logic [N*W-1:0]       pred_x_flat,
   input  logic [N*N*W-1:0]     pred_P_flat,
   output logic                 gain_start,
   input  logic                 gain_done,
   output logic                 upd_start,
   input  logic                 upd_done,
   input  logic [N*W-1:0]       upd_x_flat,
   input  logic [N*N*W-1:0]     upd_P_flat,
   output logic                 busy,
   output logic                 done,
   output logic                 skipped,
   output logic                 err_timeout,
   output logic [ICW-1:0]       iter_count
);

   seq_state_e           state_q, state_d;
   logic [N*W-1:0]       x_state_q, x_state_d, xhat_q, xhat_d;
   logic [N*N*W-1:0]     P_state_q, P_state_d, Phat_q, Phat_d;
   logic [M*W-1:0]       z_q, z_d;
   logic                 skip_q, skip_d;
   logic                 pred_start_q, pred_start_d;
   logic                 gain_start_q, gain_start_d;
   logic                 upd_start_q, upd_start_d;
   logic                 done_q, done_d;
   logic                 skipped_q, skipped_d;
   logic                 err_q, err_d;
   logic [ICW-1:0]       iter_q, iter_d;
   logic                 stage_done;
   logic                 wd_expire;

   // Done of the stage currently outstanding; dones for other stages are ignored
   always_comb begin
      stage_done = 1'b0;
      unique case (state_q)
         PREDICT: stage_done = pred_done;
         GAIN:    stage_done = gain_done;
         UPDATE:  stage_done = upd_done;
         default: stage_done = 1'b0;
      endcase
   end

   kalman_stage_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear_i  ((state_q == IDLE) || stage_done),
      .wait_i   (state_q != IDLE),
      .done_i   (stage_done),
      .expire_o (wd_expire)
   );

   // Next-state, datapath latching and output pulse generation
   always_comb begin
      state_d      = state_q;
      x_state_d    = x_state_q;
      P_state_d    = P_state_q;
      xhat_d       = xhat_q;
      Phat_d       = Phat_q;
      z_d          = z_q;
      skip_d       = skip_q;
      err_d        = err_q;
      iter_d       = iter_q;
      pred_start_d = 1'b0;
      gain_start_d = 1'b0;
      upd_start_d  = 1'b0;
      done_d       = 1'b0;
      skipped_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (init) begin
               x_state_d = x_init_flat;
               P_state_d = P_init_flat;
               iter_d    = '0;
               err_d     = 1'b0;
            end else if (start) begin
               z_d          = z_flat;
               skip_d       = ~meas_valid;
               state_d      = PREDICT;
               pred_start_d = 1'b1;
            end
         end
         PREDICT: begin
            if (pred_done) begin
               xhat_d = pred_x_flat;
               Phat_d = pred_P_flat;
               if (skip_q) begin
                  x_state_d = pred_x_flat;
                  P_state_d = pred_P_flat;
                  done_d    = 1'b1;
                  skipped_d = 1'b1;
                  iter_d    = iter_q + ICW'(1);
                  state_d   = IDLE;
               end else begin
                  gain_start_d = 1'b1;
                  state_d      = GAIN;
               end
            end else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         GAIN: begin
            if (gain_done) begin
               upd_start_d = 1'b1;
               state_d     = UPDATE;
            end else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         UPDATE: begin
            if (upd_done) begin
               x_state_d = upd_x_flat;
               P_state_d = upd_P_flat;
               done_d    = 1'b1;
               iter_d    = iter_q + ICW'(1);
               state_d   = IDLE;
            end else if (wd_expire) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, datapath and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the wide data registers are reset too, so software and engines never see X after reset.
         state_q      <= IDLE;
         x_state_q    <= '0;
         P_state_q    <= '0;
         xhat_q       <= '0;
         Phat_q       <= '0;
         z_q          <= '0;
         skip_q       <= 1'b0;
         err_q        <= 1'b0;
         iter_q       <= '0;
         pred_start_q <= 1'b0;
         gain_start_q <= 1'b0;
         upd_start_q  <= 1'b0;
         done_q       <= 1'b0;
         skipped_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_state_q    <= x_state_d;
         P_state_q    <= P_state_d;
         xhat_q       <= xhat_d;
         Phat_q       <= Phat_d;
         z_q          <= z_d;
         skip_q       <= skip_d;
         err_q        <= err_d;
         iter_q       <= iter_d;
         pred_start_q <= pred_start_d;
         gain_start_q <= gain_start_d;
         upd_start_q  <= upd_start_d;
         done_q       <= done_d;
         skipped_q    <= skipped_d;
      end
   end

   assign x_state_flat = x_state_q;
   assign P_state_flat = P_state_q;
   assign z_q_flat     = z_q;
   assign xhat_q_flat  = xhat_q;
   assign Phat_q_flat  = Phat_q;
   assign pred_start   = pred_start_q;
   assign gain_start   = gain_start_q;
   assign upd_start    = upd_start_q;
   assign busy         = (state_q != IDLE);
   assign done         = done_q;
   assign skipped      = skipped_q;
   assign err_timeout  = err_q;
   assign iter_count   = iter_q;

endmodule

// File: tb/tb_kalman_seq_ctrl.sv
// Self-checking bench for kalman_seq_ctrl: emulated engines with configurable
// latency, randomized data and a behavioural model of the committed state.
module tb_kalman_seq_ctrl;

   localparam int N       = 6;
   localparam int M       = 4;
   localparam int W       = 32;
   localparam int TIMEOUT = 16;
   localparam int ICW     = 2;
   localparam int XB      = N*W;
   localparam int PB      = N*N*W;
   localparam int ZB      = M*W;
   localparam int IMOD    = 1 << ICW;

   logic           clk, rst, init, start, meas_valid;
   logic [XB-1:0]  x_init_flat, pred_x_flat, upd_x_flat;
   logic [PB-1:0]  P_init_flat, pred_P_flat, upd_P_flat;
   logic [ZB-1:0]  z_flat;
   logic [XB-1:0]  x_state_flat, xhat_q_flat;
   logic [PB-1:0]  P_state_flat, Phat_q_flat;
   logic [ZB-1:0]  z_q_flat;
   logic           pred_start, pred_done, gain_start, gain_done, upd_start, upd_done;
   logic           busy, done, skipped, err_timeout;
   logic [ICW-1:0] iter_count;

   kalman_seq_ctrl #(
      .N(N), .M(M), .W(W), .TIMEOUT(TIMEOUT), .ICW(ICW)
   ) dut (
      .clk(clk), .rst(rst), .init(init), .x_init_flat(x_init_flat), .P_init_flat(P_init_flat),
      .start(start), .meas_valid(meas_valid), .z_flat(z_flat),
      .x_state_flat(x_state_flat), .P_state_flat(P_state_flat), .z_q_flat(z_q_flat),
      .xhat_q_flat(xhat_q_flat), .Phat_q_flat(Phat_q_flat),
      .pred_start(pred_start), .pred_done(pred_done), .pred_x_flat(pred_x_flat), .pred_P_flat(pred_P_flat),
      .gain_start(gain_start), .gain_done(gain_done),
      .upd_start(upd_start), .upd_done(upd_done), .upd_x_flat(upd_x_flat), .upd_P_flat(upd_P_flat),
      .busy(busy), .done(done), .skipped(skipped), .err_timeout(err_timeout), .iter_count(iter_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   // behavioural model of committed state
   logic [XB-1:0] exp_x, exp_xhat;
   logic [PB-1:0] exp_P, exp_Phat;
   int            exp_iter;
   logic [ZB-1:0] z_sent;

   // observations from the last run_iter
   int   obs_pred, obs_gain, obs_upd, obs_done, obs_end;
   int   dn_pred, dn_gain, dn_upd;
   int   n_pred, n_gain, n_upd, n_done;
   logic obs_skipped, err_busy;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [XB-1:0] rnd_x();
      logic [XB-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
      return v;
   endfunction

   function automatic logic [PB-1:0] rnd_p();
      logic [PB-1:0] v;
      for (int i = 0; i < N*N; i++) v[i*W +: W] = $urandom;
      return v;
   endfunction

   function automatic logic [ZB-1:0] rnd_z();
      logic [ZB-1:0] v;
      for (int i = 0; i < M; i++) v[i*W +: W] = $urandom;
      return v;
   endfunction

   function automatic logic [XB-1:0] const_x(input int val);
      logic [XB-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = val;
      return v;
   endfunction

   // Issue one start and emulate the engines: each answers dly cycles after
   // its start pulse; stage blk never answers; spur injects ignored inputs.
   task automatic run_iter(input logic meas, input int dly, input int blk, input logic spur);
      int pend, cnt;
      obs_pred = -1; obs_gain = -1; obs_upd = -1; obs_done = -1; obs_end = -1;
      dn_pred = -1; dn_gain = -1; dn_upd = -1;
      n_pred = 0; n_gain = 0; n_upd = 0; n_done = 0;
      obs_skipped = 1'bx; err_busy = err_timeout;
      z_sent = rnd_z();
      z_flat = z_sent; meas_valid = meas; start = 1'b1;
      tick();
      start = 1'b0; meas_valid = $urandom; z_flat = rnd_z();
      pend = 0; cnt = 0;
      for (int cyc = 1; cyc < 200; cyc++) begin
         pred_done = 1'b0; gain_done = 1'b0; upd_done = 1'b0; start = 1'b0; init = 1'b0;
         if (pred_start) begin n_pred++; obs_pred = cyc; pend = 1; cnt = dly; end
         if (gain_start) begin n_gain++; obs_gain = cyc; pend = 2; cnt = dly; end
         if (upd_start)  begin n_upd++;  obs_upd  = cyc; pend = 3; cnt = dly; end
         if (done)       begin n_done++; obs_done = cyc; obs_skipped = skipped; end
         if (!busy) begin obs_end = cyc; break; end
         err_busy = err_timeout;
         if (pend != 0 && pend != blk && cnt == 0) begin
            case (pend)
               1: begin pred_done = 1'b1; dn_pred = cyc; end
               2: begin gain_done = 1'b1; dn_gain = cyc; end
               default: begin upd_done = 1'b1; dn_upd = cyc; end
            endcase
            pend = 0;
         end else if (pend != 0) begin
            if (cnt > 0) cnt--;
            if (spur && pend == 1) upd_done = 1'b1;
            if (spur && pend == 2) begin start = 1'b1; init = 1'b1; end
         end
         tick();
      end
      pred_done = 1'b0; gain_done = 1'b0; upd_done = 1'b0; start = 1'b0; init = 1'b0;
      total_cnt++;
      if (obs_end < 0) $display("FAIL iter_bound: busy never dropped within 200 cycles");
      else pass_cnt++;
   endtask

   task automatic do_init();
      x_init_flat = rnd_x(); P_init_flat = rnd_p();
      init = 1'b1;
      tick();
      init = 1'b0;
      exp_x = x_init_flat; exp_P = P_init_flat; exp_iter = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0; init = 1'b0; start = 1'b0; meas_valid = 1'b0;
      pred_done = 1'b0; gain_done = 1'b0; upd_done = 1'b0;
      x_init_flat = '0; P_init_flat = '0; z_flat = '0;
      pred_x_flat = '0; pred_P_flat = '0; upd_x_flat = '0; upd_P_flat = '0;
      #1 rst = 1'b1;
      tick(); tick();
      total_cnt++;
      if ({busy, done, skipped, err_timeout, pred_start, gain_start, upd_start} !== 7'b0)
         $display("FAIL reset_ctrl: got %b want 0", {busy, done, skipped, err_timeout, pred_start, gain_start, upd_start});
      else pass_cnt++;
      total_cnt++;
      if ({x_state_flat, P_state_flat, z_q_flat, xhat_q_flat, Phat_q_flat, iter_count} !== '0)
         $display("FAIL reset_data: state/latched registers not zero");
      else pass_cnt++;
      rst = 1'b0;
      tick();
      exp_x = '0; exp_P = '0; exp_iter = 0;
   endtask

   task automatic test_init_full();
      x_init_flat = const_x(4096); P_init_flat = rnd_p();
      init = 1'b1; tick(); init = 1'b0;
      exp_x = x_init_flat; exp_P = P_init_flat; exp_iter = 0;
      total_cnt++;
      if (x_state_flat !== exp_x || P_state_flat !== exp_P || iter_count !== 2'd0)
         $display("FAIL init_load: x got %h want %h iter %0d", x_state_flat, exp_x, iter_count);
      else pass_cnt++;
      pred_x_flat = rnd_x(); pred_P_flat = rnd_p();
      upd_x_flat = const_x(8192); upd_P_flat = rnd_p();
      run_iter(1'b1, 3, 0, 1'b0);
      exp_x = upd_x_flat; exp_P = upd_P_flat; exp_iter = (exp_iter + 1) % IMOD;
      total_cnt++;
      if (obs_pred != 1 || obs_gain != dn_pred + 1 || obs_upd != dn_gain + 1 || dn_pred != 4)
         $display("FAIL full_order: pred %0d gain %0d upd %0d want 1,%0d,%0d", obs_pred, obs_gain, obs_upd, dn_pred + 1, dn_gain + 1);
      else pass_cnt++;
      total_cnt++;
      if (obs_done != dn_upd + 1 || n_done != 1 || obs_skipped !== 1'b0)
         $display("FAIL full_done: cycle %0d want %0d count %0d skipped %b", obs_done, dn_upd + 1, n_done, obs_skipped);
      else pass_cnt++;
      total_cnt++;
      if (x_state_flat !== exp_x || P_state_flat !== exp_P)
         $display("FAIL full_commit: x got %h want %h", x_state_flat, exp_x);
      else pass_cnt++;
      total_cnt++;
      if (iter_count !== ICW'(exp_iter)) $display("FAIL full_iter: got %0d want %0d", iter_count, exp_iter);
      else pass_cnt++;
      total_cnt++;
      if (xhat_q_flat !== pred_x_flat || Phat_q_flat !== pred_P_flat || z_q_flat !== z_sent)
         $display("FAIL full_latch: xhat %h want %h z %h want %h", xhat_q_flat, pred_x_flat, z_q_flat, z_sent);
      else pass_cnt++;
   endtask

   task automatic test_predict_only();
      pred_x_flat = const_x(410); pred_P_flat = rnd_p();
      upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
      run_iter(1'b0, 2, 0, 1'b0);
      exp_x = pred_x_flat; exp_P = pred_P_flat; exp_iter = (exp_iter + 1) % IMOD;
      total_cnt++;
      if (n_gain != 0 || n_upd != 0) $display("FAIL skip_pulses: gain %0d upd %0d want 0,0", n_gain, n_upd);
      else pass_cnt++;
      total_cnt++;
      if (obs_done != dn_pred + 1 || obs_skipped !== 1'b1)
         $display("FAIL skip_done: cycle %0d want %0d skipped %b want 1", obs_done, dn_pred + 1, obs_skipped);
      else pass_cnt++;
      total_cnt++;
      if (x_state_flat !== exp_x || P_state_flat !== exp_P || iter_count !== ICW'(exp_iter))
         $display("FAIL skip_commit: x got %h want %h iter %0d want %0d", x_state_flat, exp_x, iter_count, exp_iter);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 8; k++) begin
         logic meas;
         int   dly;
         meas = $urandom_range(0, 1);
         dly  = $urandom_range(0, 4);
         pred_x_flat = rnd_x(); pred_P_flat = rnd_p();
         upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
         run_iter(meas, dly, 0, 1'b0);
         if (meas) begin exp_x = upd_x_flat; exp_P = upd_P_flat; end
         else begin exp_x = pred_x_flat; exp_P = pred_P_flat; end
         exp_iter = (exp_iter + 1) % IMOD;
         total_cnt++;
         if (n_done != 1 || obs_skipped !== !meas || obs_done != (meas ? dn_upd : dn_pred) + 1 || n_gain != int'(meas))
            $display("FAIL b2b_flow[%0d]: done %0d@%0d skipped %b gain %0d meas %b dly %0d", k, n_done, obs_done, obs_skipped, n_gain, meas, dly);
         else pass_cnt++;
         total_cnt++;
         if (x_state_flat !== exp_x || P_state_flat !== exp_P || iter_count !== ICW'(exp_iter) || xhat_q_flat !== pred_x_flat)
            $display("FAIL b2b_state[%0d]: x got %h want %h iter %0d want %0d", k, x_state_flat, exp_x, iter_count, exp_iter);
         else pass_cnt++;
      end
   endtask

   task automatic test_ignored();
      // stray dones while idle
      pred_done = 1'b1; gain_done = 1'b1; upd_done = 1'b1;
      tick();
      pred_done = 1'b0; gain_done = 1'b0; upd_done = 1'b0;
      tick();
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || iter_count !== ICW'(exp_iter) || x_state_flat !== exp_x)
         $display("FAIL idle_dones: busy %b done %b iter %0d want %0d", busy, done, iter_count, exp_iter);
      else pass_cnt++;
      // upd_done during PREDICT, start+init during GAIN
      x_init_flat = rnd_x(); P_init_flat = rnd_p();
      pred_x_flat = rnd_x(); pred_P_flat = rnd_p();
      upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
      run_iter(1'b1, 3, 0, 1'b1);
      exp_x = upd_x_flat; exp_P = upd_P_flat; exp_iter = (exp_iter + 1) % IMOD;
      total_cnt++;
      if (n_pred != 1 || n_gain != 1 || n_upd != 1 || n_done != 1 || obs_upd != dn_gain + 1)
         $display("FAIL spur_flow: pred %0d gain %0d upd %0d done %0d want 1 each", n_pred, n_gain, n_upd, n_done);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (busy !== 1'b0 || x_state_flat !== exp_x || P_state_flat !== exp_P || iter_count !== ICW'(exp_iter))
         $display("FAIL spur_state: busy %b x got %h want %h iter %0d want %0d", busy, x_state_flat, exp_x, iter_count, exp_iter);
      else pass_cnt++;
   endtask

   task automatic test_watchdog();
      do_init();
      pred_x_flat = rnd_x(); pred_P_flat = rnd_p();
      upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
      run_iter(1'b1, 2, 2, 1'b0);
      total_cnt++;
      if (obs_end != obs_gain + TIMEOUT || err_busy !== 1'b0)
         $display("FAIL wd_timing: idle at %0d want %0d err before %b", obs_end, obs_gain + TIMEOUT, err_busy);
      else pass_cnt++;
      total_cnt++;
      if (err_timeout !== 1'b1 || busy !== 1'b0 || n_done != 0 || n_upd != 0)
         $display("FAIL wd_abort: err %b busy %b done %0d upd %0d", err_timeout, busy, n_done, n_upd);
      else pass_cnt++;
      total_cnt++;
      if (x_state_flat !== exp_x || P_state_flat !== exp_P || iter_count !== ICW'(exp_iter) || xhat_q_flat !== pred_x_flat)
         $display("FAIL wd_state: x got %h want %h iter %0d want %0d", x_state_flat, exp_x, iter_count, exp_iter);
      else pass_cnt++;
      // a new start is still accepted with the error flagged
      pred_x_flat = rnd_x(); pred_P_flat = rnd_p();
      upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
      run_iter(1'b1, 1, 0, 1'b0);
      exp_x = upd_x_flat; exp_P = upd_P_flat; exp_iter = (exp_iter + 1) % IMOD;
      total_cnt++;
      if (n_done != 1 || err_timeout !== 1'b1 || x_state_flat !== exp_x || iter_count !== ICW'(exp_iter))
         $display("FAIL wd_restart: done %0d err %b iter %0d want %0d", n_done, err_timeout, iter_count, exp_iter);
      else pass_cnt++;
      do_init();
      total_cnt++;
      if (err_timeout !== 1'b0 || x_state_flat !== exp_x) $display("FAIL wd_clear: err %b want 0", err_timeout);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      do_init();
      for (int k = 1; k <= 4; k++) begin
         pred_x_flat = rnd_x(); pred_P_flat = rnd_p();
         upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
         run_iter(1'($urandom_range(0, 1)), 1, 0, 1'b0);
         exp_iter = (exp_iter + 1) % IMOD;
         total_cnt++;
         if (iter_count !== ICW'(k % IMOD)) $display("FAIL wrap[%0d]: got %0d want %0d", k, iter_count, k % IMOD);
         else pass_cnt++;
      end
      x_init_flat = rnd_x(); P_init_flat = rnd_p();
      init = 1'b1; start = 1'b1; meas_valid = 1'b1;
      tick();
      init = 1'b0; start = 1'b0;
      exp_x = x_init_flat; exp_P = P_init_flat; exp_iter = 0;
      total_cnt++;
      if (busy !== 1'b0 || pred_start !== 1'b0 || x_state_flat !== exp_x || P_state_flat !== exp_P || iter_count !== 2'd0)
         $display("FAIL init_prio: busy %b pred_start %b iter %0d x got %h want %h", busy, pred_start, iter_count, x_state_flat, exp_x);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL init_prio_hold: busy %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic seen;
      seen = 1'b0;
      start = 1'b1; meas_valid = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         pred_done = pred_start;
         gain_done = gain_start;
         if (upd_start) seen = 1'b1;
         else tick();
      end
      pred_done = 1'b0; gain_done = 1'b0;
      total_cnt++;
      if (!seen) $display("FAIL rst_reach: UPDATE never entered");
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({busy, done, skipped, err_timeout, pred_start, gain_start, upd_start} !== 7'b0 ||
          {x_state_flat, P_state_flat, z_q_flat, xhat_q_flat, Phat_q_flat, iter_count} !== '0)
         $display("FAIL rst_mid: ctrl %b iter %0d x %h want all 0", {busy, done, skipped, err_timeout, pred_start, gain_start, upd_start}, iter_count, x_state_flat);
      else pass_cnt++;
      tick();
      rst = 1'b0;
      upd_x_flat = rnd_x(); upd_P_flat = rnd_p();
      upd_done = 1'b1;
      tick();
      upd_done = 1'b0;
      tick();
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0 || x_state_flat !== '0 || iter_count !== 2'd0)
         $display("FAIL rst_late_done: busy %b done %b iter %0d x %h", busy, done, iter_count, x_state_flat);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_init_full();
      test_predict_only();
      test_back_to_back();
      test_ignored();
      test_watchdog();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

endmodule
